// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extract/extend slot with a 2-entry skid buffer (main + skid).
// Optional macro IMM_BR_SHIFT_EN: CB19/B26 results are shifted left by 2 (byte offsets).
module imm_extend_pipe #(
  parameter int DATA_W = 64,
  parameter int MODE_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [MODE_W-1:0] mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] imm_out,
  output logic              imm_err
);

  // Handshake: a beat transfers on an edge where valid && ready; the producer
  // keeps data stable while valid is high and ready is low; ready does not
  // depend on valid (in_ready is a pure function of registered skid state).

  localparam logic [MODE_W-1:0] MODE_D9    = MODE_W'(0);
  localparam logic [MODE_W-1:0] MODE_I12   = MODE_W'(1);
  localparam logic [MODE_W-1:0] MODE_CB19  = MODE_W'(2);
  localparam logic [MODE_W-1:0] MODE_B26   = MODE_W'(3);
  localparam logic [MODE_W-1:0] MODE_MOV16 = MODE_W'(4);

  // ---------------------------------------------------------------------
  // Combinational extraction
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] d9_ext;
  logic [DATA_W-1:0] i12_ext;
  logic [DATA_W-1:0] cb19_sext;
  logic [DATA_W-1:0] b26_sext;
  logic [DATA_W-1:0] cb19_ext;
  logic [DATA_W-1:0] b26_ext;
  logic [63:0]       mov_wide;
  logic [DATA_W-1:0] mov_ext;
  logic              mov_bad;
  logic [DATA_W-1:0] new_imm;
  logic              new_err;
  logic              unused_instr_bits;

  assign unused_instr_bits = ^instr[31:26];

  assign d9_ext    = {{(DATA_W-9){instr[20]}}, instr[20:12]};
  assign i12_ext   = {{(DATA_W-12){1'b0}}, instr[21:10]};
  assign cb19_sext = {{(DATA_W-19){instr[23]}}, instr[23:5]};
  assign b26_sext  = {{(DATA_W-26){instr[25]}}, instr[25:0]};

`ifdef IMM_BR_SHIFT_EN
  assign cb19_ext = {cb19_sext[DATA_W-3:0], 2'b00};
  assign b26_ext  = {b26_sext[DATA_W-3:0], 2'b00};
`else
  assign cb19_ext = cb19_sext;
  assign b26_ext  = b26_sext;
`endif

  // MOV16 is built at 64 bits, then truncated; hw>=2 cannot fit a 32-bit result.
  assign mov_wide = {48'b0, instr[20:5]} << {instr[22:21], 4'b0000};
  assign mov_ext  = mov_wide[DATA_W-1:0];
  assign mov_bad  = (DATA_W == 32) && instr[22];

  always_comb begin
    new_imm = '0;
    new_err = 1'b0;
    case (mode)
      MODE_D9:    new_imm = d9_ext;
      MODE_I12:   new_imm = i12_ext;
      MODE_CB19:  new_imm = cb19_ext;
      MODE_B26:   new_imm = b26_ext;
      MODE_MOV16: begin
        if (mov_bad) begin
          new_err = 1'b1;
        end else begin
          new_imm = mov_ext;
        end
      end
      default:    new_err = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------
  // Main register + skid register
  // ---------------------------------------------------------------------
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              err_q, err_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_imm_q, skid_imm_d;
  logic              skid_err_q, skid_err_d;
  logic              accept;
  logic              drain;

  assign in_ready  = ~skid_valid_q;
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid_q & out_ready;
  assign out_valid = out_valid_q;
  assign imm_out   = imm_q;
  assign imm_err   = err_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    imm_d        = imm_q;
    err_d        = err_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_err_d   = skid_err_q;
    if (flush) begin
      // Squash wins over any same-cycle accept or drain; data is left as-is.
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (drain && skid_valid_q) begin
      imm_d        = skid_imm_q;
      err_d        = skid_err_q;
      skid_valid_d = 1'b0;
    end else if (accept && (!out_valid_q || drain)) begin
      out_valid_d  = 1'b1;
      imm_d        = new_imm;
      err_d        = new_err;
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = new_imm;
      skid_err_d   = new_err;
    end else if (drain) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      imm_q        <= '0;
      err_q        <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_err_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      imm_q        <= imm_d;
      err_q        <= err_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_err_q   <= skid_err_d;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: directed tasks plus a queue scoreboard.
module tb_imm_extend_pipe;
  localparam int W = 64;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [31:0]   instr = '0;
  logic [2:0]    mode = '0;
  logic          in_ready, out_valid, imm_err;
  logic [W-1:0]  imm_out;
  logic          in_ready32, out_valid32, imm_err32;
  logic [31:0]   imm_out32;

  int            n_vec = 0;
  int            n_err = 0;
  logic [W:0]    exp_q[$];
  logic [W:0]    sb_e;

  imm_extend_pipe #(.DATA_W(64), .MODE_W(3)) u_dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .instr(instr), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .imm_out(imm_out), .imm_err(imm_err)
  );

  imm_extend_pipe #(.DATA_W(32), .MODE_W(3)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready32), .instr(instr), .mode(mode), .out_valid(out_valid32),
    .out_ready(out_ready), .imm_out(imm_out32), .imm_err(imm_err32)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model (DATA_W=64) ----------------
  function automatic logic [W:0] model(input logic [31:0] ins, input logic [2:0] md);
    longint             v;
    logic signed [8:0]  s9;
    logic signed [18:0] s19;
    logic signed [25:0] s26;
    logic [63:0]        r;
    case (md)
      3'd0: begin s9 = ins[20:12]; v = longint'(s9); return {1'b0, v}; end
      3'd1: begin r = '0; r[11:0] = ins[21:10]; return {1'b0, r}; end
      3'd2: begin
        s19 = ins[23:5]; v = longint'(s19);
`ifdef IMM_BR_SHIFT_EN
        v = v * 4;
`endif
        return {1'b0, v};
      end
      3'd3: begin
        s26 = ins[25:0]; v = longint'(s26);
`ifdef IMM_BR_SHIFT_EN
        v = v * 4;
`endif
        return {1'b0, v};
      end
      3'd4: begin
        v = longint'(ins[20:5]) * (longint'(1) << (16 * ins[22:21]));
        return {1'b0, v};
      end
      default: return {1'b1, 64'd0};
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!reset_n || flush) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected: got err=%b imm=%h, required no output", imm_err, imm_out);
        end else begin
          sb_e = exp_q.pop_front();
          if ({imm_err, imm_out} !== sb_e) begin
            n_err++;
            $display("FAIL sb_data: got err=%b imm=%h, required err=%b imm=%h",
                     imm_err, imm_out, sb_e[W], sb_e[W-1:0]);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(instr, mode));
    end
  end

  // ---------------- driver helpers ----------------
  task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] md);
    in_valid = v;
    instr    = ins;
    mode     = md;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) step();
    n_vec++;
    if ({out_valid, imm_err, imm_out, in_ready} !== {1'b0, 1'b0, 64'd0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_state: got v=%b e=%b imm=%h rdy=%b, required 0 0 0 1",
               out_valid, imm_err, imm_out, in_ready);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_modes();
    logic [31:0] t_ins[7];
    logic [2:0]  t_md[7];
    logic [W:0]  t_exp[7];
    t_ins[0] = 32'h001F_F000; t_md[0] = 3'd0; t_exp[0] = {1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
    t_ins[1] = 32'h003F_FC00; t_md[1] = 3'd1; t_exp[1] = {1'b0, 64'h0000_0000_0000_0FFF};
    t_ins[2] = 32'h0200_0000; t_md[2] = 3'd3;
`ifdef IMM_BR_SHIFT_EN
    t_exp[2] = {1'b0, 64'hFFFF_FFFF_F800_0000};
`else
    t_exp[2] = {1'b0, 64'hFFFF_FFFF_FE00_0000};
`endif
    t_ins[3] = 32'h0077_DDE0; t_md[3] = 3'd4; t_exp[3] = {1'b0, 64'hBEEF_0000_0000_0000};
    t_ins[4] = 32'hFFFF_FFFF; t_md[4] = 3'd6; t_exp[4] = {1'b1, 64'd0};
    t_ins[5] = 32'h0080_0000; t_md[5] = 3'd2;
`ifdef IMM_BR_SHIFT_EN
    t_exp[5] = {1'b0, 64'hFFFF_FFFF_FFF0_0000};
`else
    t_exp[5] = {1'b0, 64'hFFFF_FFFF_FFFC_0000};
`endif
    t_ins[6] = 32'h000F_F000; t_md[6] = 3'd0; t_exp[6] = {1'b0, 64'h0000_0000_0000_00FF};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, t_ins[i], t_md[i]);
      step();
      n_vec++;
      if ({out_valid, in_ready, imm_err, imm_out} !== {1'b1, 1'b1, t_exp[i]}) begin
        n_err++;
        $display("FAIL mode_row%0d: got v=%b rdy=%b e=%b imm=%h, required 1 1 %b %h",
                 i, out_valid, in_ready, imm_err, imm_out, t_exp[i][W], t_exp[i][W-1:0]);
      end
    end
    drive(1'b0, '0, '0);
    step();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mode_idle: got out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_mov16_width();
    out_ready = 1'b1;
    drive(1'b1, 32'h0077_DDE0, 3'd4);
    step();
    n_vec++;
    if ({imm_err, imm_out, imm_err32, imm_out32} !==
        {1'b0, 64'hBEEF_0000_0000_0000, 1'b1, 32'h0}) begin
      n_err++;
      $display("FAIL mov16_hw3: got w64 e=%b imm=%h w32 e=%b imm=%h, required 0 beef000000000000 1 0",
               imm_err, imm_out, imm_err32, imm_out32);
    end
    drive(1'b1, 32'h0037_DDE0, 3'd4);
    step();
    n_vec++;
    if ({imm_err, imm_out, imm_err32, imm_out32} !==
        {1'b0, 64'h0000_0000_BEEF_0000, 1'b0, 32'hBEEF_0000}) begin
      n_err++;
      $display("FAIL mov16_hw1: got w64 e=%b imm=%h w32 e=%b imm=%h, required 0 beef0000 0 beef0000",
               imm_err, imm_out, imm_err32, imm_out32);
    end
    drive(1'b0, '0, '0);
    step();
  endtask

  task automatic test_backpressure();
    logic [31:0] c1, c2, c3;
    logic [W:0]  e1, e2;
    c1 = 32'h0000_0020;            // field 19'h00001
    c2 = 32'h00FF_FFE0;            // field 19'h7FFFF
    c3 = {8'h00, 19'h12345, 5'h0};
    e1 = model(c1, 3'd2);
    e2 = model(c2, 3'd2);
    out_ready = 1'b0;
    drive(1'b1, c1, 3'd2);
    step();
    n_vec++;
    if ({out_valid, in_ready, imm_err, imm_out} !== {1'b1, 1'b1, e1}) begin
      n_err++;
      $display("FAIL bp_first: got v=%b rdy=%b imm=%h, required 1 1 %h", out_valid, in_ready, imm_out, e1[W-1:0]);
    end
    drive(1'b1, c2, 3'd2);
    step();
    n_vec++;
    if ({out_valid, in_ready, imm_err, imm_out} !== {1'b1, 1'b0, e1}) begin
      n_err++;
      $display("FAIL bp_skid_full: got v=%b rdy=%b imm=%h, required 1 0 %h", out_valid, in_ready, imm_out, e1[W-1:0]);
    end
    drive(1'b1, c3, 3'd2);
    step();
    n_vec++;
    if ({out_valid, in_ready, imm_err, imm_out} !== {1'b1, 1'b0, e1}) begin
      n_err++;
      $display("FAIL bp_hold: got v=%b rdy=%b imm=%h, required 1 0 %h", out_valid, in_ready, imm_out, e1[W-1:0]);
    end
    drive(1'b0, '0, '0);
    out_ready = 1'b1;
    step();
    n_vec++;
    if ({out_valid, in_ready, imm_err, imm_out} !== {1'b1, 1'b1, e2}) begin
      n_err++;
      $display("FAIL bp_second: got v=%b rdy=%b imm=%h, required 1 1 %h", out_valid, in_ready, imm_out, e2[W-1:0]);
    end
    step();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_no_third: got out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h001F_F000, 3'd0);
    step();
    drive(1'b1, 32'h003F_FC00, 3'd1);
    step();
    flush = 1'b1;
    drive(1'b1, 32'h0200_0000, 3'd3);
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    n_vec++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL flush_full: got v=%b rdy=%b, required 0 1", out_valid, in_ready);
    end
    // Flush with in_ready high: the same-cycle accept must be dropped.
    drive(1'b1, 32'h001F_F000, 3'd0);
    step();
    flush = 1'b1;
    drive(1'b1, 32'h000F_F000, 3'd0);
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    out_ready = 1'b1;
    n_vec++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL flush_accept: got v=%b rdy=%b, required 0 1", out_valid, in_ready);
    end
    repeat (2) step();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_no_ghost: got out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h001F_F000, 3'd0);
    step();
    drive(1'b1, 32'h003F_FC00, 3'd1);
    step();
    drive(1'b0, '0, '0);
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, imm_err, imm_out, in_ready} !== {1'b0, 1'b0, 64'd0, 1'b1}) begin
      n_err++;
      $display("FAIL async_reset: got v=%b e=%b imm=%h rdy=%b, required 0 0 0 1",
               out_valid, imm_err, imm_out, in_ready);
    end
    #3 reset_n = 1'b1;
    step();
    out_ready = 1'b1;
    drive(1'b1, 32'h1234_5678, 3'd6);
    step();
    n_vec++;
    if ({out_valid, imm_err, imm_out} !== {1'b1, 1'b1, 64'd0}) begin
      n_err++;
      $display("FAIL illegal_mode6: got v=%b e=%b imm=%h, required 1 1 0", out_valid, imm_err, imm_out);
    end
    drive(1'b0, '0, '0);
    step();
  endtask

  task automatic test_random();
    logic          hold_chk;
    logic [W:0]    held;
    hold_chk = 1'b0;
    held     = '0;
    for (int i = 0; i < 400; i++) begin
      if (hold_chk) begin
        n_vec++;
        if ({out_valid, imm_err, imm_out} !== {1'b1, held}) begin
          n_err++;
          $display("FAIL stall_stable: got v=%b e=%b imm=%h, required 1 %b %h",
                   out_valid, imm_err, imm_out, held[W], held[W-1:0]);
        end
      end
      drive($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)));
      out_ready = $urandom_range(0, 2) != 0;
      flush     = $urandom_range(0, 39) == 0;
      hold_chk  = out_valid && !out_ready && !flush;
      held      = {imm_err, imm_out};
      step();
    end
    flush = 1'b0;
    drive(1'b0, '0, '0);
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_modes();
    test_mov16_width();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    step();
    n_vec++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL final_drain: got %0d pending, out_valid=%b, required 0 pending, 0", exp_q.size(), out_valid);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
